// File: rtl/arbitro_compuertas_pkg.sv
// Shared types for the gate arbiter.
//   op_e     : 3-bit gate select shared by both requesters.
//   estado_e : arbiter FSM state.
package arbitro_compuertas_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOT  = 3'd3,   // ~a, b ignored
        OP_NAND = 3'd4,
        OP_YES  = 3'd5,   // a passthrough, b ignored
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        CALC    = 2'd1,
        ENTREGA = 2'd2
    } estado_e;

endpackage

// File: rtl/arbitro_compuertas_banco.sv
// banco_compuertas: combinational bitwise gate bank.
//   a, b : operands (ANCHO bits)
//   op   : gate select
//   y    : bitwise result
module banco_compuertas
    import arbitro_compuertas_pkg::*;
#(
    parameter int ANCHO = 1
) (
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  op_e              op,
    output logic [ANCHO-1:0] y
);

    always_comb begin
        y = a & b;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_NAND: y = ~(a & b);
            OP_YES:  y = a;
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/arbitro_compuertas.sv
// arbitro_compuertas: round-robin arbiter between two requesters sharing one
// gate bank. One operation in flight: LIBRE (accept) -> CALC (evaluate and
// register) -> ENTREGA (hold result until consumer takes it).
//   clk, rst             : clock, synchronous active-high reset
//   reqN_valid/ready     : requester N handshake (N = 0, 1)
//   reqN_op, reqN_a/b    : requester N gate select and operands
//   res_valid/ready      : result handshake
//   res_data, res_id     : result and owning requester
module arbitro_compuertas
    import arbitro_compuertas_pkg::*;
#(
    parameter int ANCHO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [ANCHO-1:0] req0_a,
    input  logic [ANCHO-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [ANCHO-1:0] req1_a,
    input  logic [ANCHO-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ANCHO-1:0] res_data,
    output logic             res_id
);

    estado_e          estado_q, estado_d;
    op_e              op_q, op_d;
    logic [ANCHO-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [ANCHO-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             ultimo_q, ultimo_d;   // requester served last

    logic             algun_valid;
    logic             gnt_id;
    logic [ANCHO-1:0] y;

    banco_compuertas #(.ANCHO(ANCHO)) u_banco (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (y)
    );

    // With both valid, favour whoever was not served last; otherwise the
    // single valid requester wins regardless of the pointer.
    assign algun_valid = req0_valid | req1_valid;
    assign gnt_id      = (req0_valid & req1_valid) ? ~ultimo_q : req1_valid & ~req0_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= LIBRE;
            op_q       <= OP_AND;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            ultimo_q   <= 1'b1;   // requester 0 wins the first tie
        end else begin
            estado_q   <= estado_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            ultimo_q   <= ultimo_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        estado_d   = estado_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        ultimo_d   = ultimo_q;
        case (estado_q)
            LIBRE: begin
                if (algun_valid) begin
                    op_d     = gnt_id ? op_e'(req1_op) : op_e'(req0_op);
                    a_d      = gnt_id ? req1_a : req0_a;
                    b_d      = gnt_id ? req1_b : req0_b;
                    id_d     = gnt_id;
                    estado_d = CALC;
                end
            end
            CALC: begin
                res_data_d = y;
                res_id_d   = id_q;
                estado_d   = ENTREGA;
            end
            ENTREGA: begin
                // Pointer moves only when the result is actually consumed.
                if (res_ready) begin
                    ultimo_d = res_id_q;
                    estado_d = LIBRE;
                end
            end
            default: estado_d = LIBRE;
        endcase
    end

    // Outputs
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && estado_q == LIBRE && algun_valid) begin
            req0_ready = ~gnt_id;
            req1_ready = gnt_id;
        end
    end

    assign res_valid = (estado_q == ENTREGA);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_arbitro_compuertas.sv
module tb_arbitro_compuertas;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       res_ready = 1'b1;

    // ANCHO=1 instance
    logic       req0_valid = 0, req1_valid = 0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = 0, req1_op = 0;
    logic       req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       res_valid, res_data, res_id;

    // ANCHO=4 instance
    logic       w_req0_valid = 0, w_req1_valid = 0;
    logic       w_req0_ready, w_req1_ready;
    logic [2:0] w_req0_op = 0, w_req1_op = 0;
    logic [3:0] w_req0_a = 0, w_req0_b = 0, w_req1_a = 0, w_req1_b = 0;
    logic       w_res_valid, w_res_id;
    logic [3:0] w_res_data;

    int checks = 0;
    int errors = 0;

    // Truth table per opcode: bit {a,b} holds the expected result.
    logic [3:0] tt [8];

    always #5 clk = ~clk;

    arbitro_compuertas #(.ANCHO(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    arbitro_compuertas #(.ANCHO(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_op(w_req0_op),
        .req0_a(w_req0_a), .req0_b(w_req0_b),
        .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_op(w_req1_op),
        .req1_a(w_req1_a), .req1_b(w_req1_b),
        .res_valid(w_res_valid), .res_ready(res_ready),
        .res_data(w_res_data), .res_id(w_res_id)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] exp_id;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0011;
        tt[4] = 4'b0111; tt[5] = 4'b1100; tt[6] = 4'b0001; tt[7] = 4'b1001;

        // Reset state; ready must stay low under reset even with valid.
        step(); step();
        chk("rst_res_valid", 4'(res_valid), 4'h0);
        chk("rst_res_data",  4'(res_data),  4'h0);
        chk("rst_res_id",    4'(res_id),    4'h0);
        chk("rst_w_res_data", w_res_data,   4'h0);
        req0_valid = 1; req0_op = 3'd0; req0_a = 1; req0_b = 1;
        #1;
        chk("rst_req0_ready", 4'(req0_ready), 4'h0);

        // Single AND op: ready in cycle 0, result at cycle 2.
        step();
        rst = 0;
        #1;
        chk("c0_req0_ready", 4'(req0_ready), 4'h1);
        chk("c0_req1_ready", 4'(req1_ready), 4'h0);
        step();
        req0_valid = 0;
        chk("c1_res_valid", 4'(res_valid), 4'h0);
        chk("c1_req0_ready", 4'(req0_ready), 4'h0);
        step();
        chk("c2_res_valid", 4'(res_valid), 4'h1);
        chk("c2_res_data",  4'(res_data),  4'h1);
        chk("c2_res_id",    4'(res_id),    4'h0);
        step();
        chk("c3_res_valid", 4'(res_valid), 4'h0);

        // Round robin with both valid: ids 0,1,0,1, data 1,0,1,0.
        rst = 1;
        step();
        rst = 0;
        req0_valid = 1; req0_op = 3'd2; req0_a = 0; req0_b = 1;
        req1_valid = 1; req1_op = 3'd7; req1_a = 0; req1_b = 1;
        for (int k = 0; k < 4; k++) begin
            exp_id = 2'(k % 2);
            #1;
            chk("rr_req0_ready", 4'(req0_ready), 4'(exp_id == 0));
            chk("rr_req1_ready", 4'(req1_ready), 4'(exp_id == 1));
            step();
            step();
            chk("rr_res_valid", 4'(res_valid), 4'h1);
            chk("rr_res_id",    4'(res_id),    4'(exp_id));
            chk("rr_res_data",  4'(res_data),  4'(exp_id == 0));
            step();
        end

        // Opcode sweep on requester 1 alone.
        req0_valid = 0;
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                logic [3:0] row;
                row = tt[op];
                req1_op = 3'(op); req1_a = ab[1]; req1_b = ab[0];
                #1;
                chk("sw_req1_ready", 4'(req1_ready), 4'h1);
                step();
                // Changes while not in LIBRE must not disturb the operation.
                req1_a = ~req1_a; req1_op = ~req1_op;
                step();
                chk("sw_res_id",   4'(res_id),   4'h1);
                chk("sw_res_data", 4'(res_data), 4'(row[ab]));
                step();
            end
        end

        // Back-pressure: last served is 1, so requester 0 wins the tie.
        req0_valid = 1; req0_op = 3'd1; req0_a = 1; req0_b = 0;
        req1_valid = 1; req1_op = 3'd0; req1_a = 0; req1_b = 0;
        res_ready = 0;
        #1;
        chk("bp_req0_ready", 4'(req0_ready), 4'h1);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_res_valid", 4'(res_valid), 4'h1);
            chk("bp_res_data",  4'(res_data),  4'h1);
            chk("bp_res_id",    4'(res_id),    4'h0);
            chk("bp_readys",    4'({req0_ready, req1_ready}), 4'h0);
            step();
        end
        res_ready = 1;
        step();
        chk("bp_release_valid", 4'(res_valid), 4'h0);
        #1;
        chk("bp_next_req1_ready", 4'(req1_ready), 4'h1);
        chk("bp_next_req0_ready", 4'(req0_ready), 4'h0);

        // Reset during CALC discards the requester-1 operation.
        step();
        rst = 1;
        #1;
        chk("rc_readys_in_rst", 4'({req0_ready, req1_ready}), 4'h0);
        step();
        chk("rc_res_valid", 4'(res_valid), 4'h0);
        rst = 0;
        #1;
        chk("rc_req0_ready", 4'(req0_ready), 4'h1);
        chk("rc_req1_ready", 4'(req1_ready), 4'h0);
        req0_valid = 0; req1_valid = 0;
        step();
        chk("rc_no_result", 4'(res_valid), 4'h0);
        step();
        chk("rc_no_result2", 4'(res_valid), 4'h0);

        // ANCHO=4 NAND.
        w_req0_valid = 1; w_req0_op = 3'd4; w_req0_a = 4'b1100; w_req0_b = 4'b1010;
        #1;
        chk("w_req0_ready", 4'(w_req0_ready), 4'h1);
        step();
        w_req0_valid = 0;
        step();
        chk("w_res_valid", 4'(w_res_valid), 4'h1);
        chk("w_res_data",  w_res_data,      4'b0111);
        chk("w_res_id",    4'(w_res_id),    4'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_compuertas.md
ARBITRO_COMPUERTAS -- requirements
Module: arbitro_compuertas

Interface
REQ-001 Parameter: ANCHO, 1, operand/result width in bits (bitwise gate operations).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_valid  input  1  requester 0 presents an operation.
REQ-005 Port: req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 Port: req0_op  input  3  requester 0 gate select.
REQ-007 Port: req0_a, req0_b  input  ANCHO  requester 0 operands.
REQ-008 Port: req1_valid, req1_ready, req1_op, req1_a, req1_b  same as REQ-004..007, for requester 1.
REQ-009 Port: res_valid  output  1  result available.
REQ-010 Port: res_ready  input  1  consumer takes result.
REQ-011 Port: res_data  output  ANCHO  gate result.
REQ-012 Port: res_id  output  1  requester that owns res_data (0 or 1).

Function
REQ-013 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOT(a), 4 NAND, 5 YES(a)=a, 6 NOR, 7 XNOR; all 8 codes defined, b ignored for 3 and 5.
REQ-014 FSM states SHALL be LIBRE, CALC, ENTREGA.
REQ-015 In LIBRE, ready SHALL be asserted combinationally for exactly one requester with valid=1, selected per REQ-018; no ready when neither is valid; ready SHALL be 0 in CALC and ENTREGA.
REQ-016 Handshake (valid & ready at an edge) in LIBRE SHALL latch op, a, b and id into internal registers and move to CALC.
REQ-017 CALC SHALL register the gate result into res_data and res_id, and move to ENTREGA after one cycle; res_valid SHALL be 1 throughout ENTREGA.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant goes to the requester not served last; with one valid, that one is granted regardless of pointer.
REQ-019 The last-served pointer SHALL update only on result handshake (res_valid & res_ready).
REQ-020 In ENTREGA, res_data/res_id SHALL stay stable until res_ready=1; on that edge return to LIBRE with res_valid=0 next cycle.
REQ-021 Latency: handshake at edge T yields res_valid=1 from edge T+2; minimum 3 cycles per operation when res_ready is held 1.
REQ-022 Requester inputs changing while not granted SHALL have no effect; a requester dropping valid before grant is not served.

Reset
REQ-023 With rst=1 at an edge: state=LIBRE, res_valid=0, res_data=0, res_id=0, pointer favours requester 0 next.
REQ-024 rst in CALC or ENTREGA SHALL discard the transaction with no result delivered; rst SHALL dominate every other input.
REQ-025 req0_ready and req1_ready SHALL be 0 while rst=1.

Structure
REQ-026 Shared package SHALL hold the opcode enumeration (3-bit) and the FSM state enumeration.
REQ-027 Gate evaluation SHALL be one combinational sub-module banco_compuertas (inputs a, b, op; output y; width ANCHO), instantiated once and shared by both requesters.

Verification
REQ-028 After reset, req0_valid=1, op=0, a=1, b=1 (ANCHO=1) -> req0_ready=1 in cycle 0, res_valid=1 at cycle 2, res_data=1, res_id=0.
REQ-029 Both valid continuously, res_ready=1, req0 op=2 a=0 b=1, req1 op=7 a=0 b=1 -> results alternate id 0,1,0,1 with data 1,0,1,0, one every 3 cycles.
REQ-030 Sweep all 8 opcodes for (a,b) in {00,01,10,11} on requester 1 -> res_data matches REQ-013 truth table in every case.
REQ-031 res_ready=0 for 5 cycles in ENTREGA -> res_valid, res_data, res_id stable; req*_ready stay 0; pointer unchanged.
REQ-032 rst=1 asserted in CALC -> next cycle res_valid=0, state LIBRE, no result delivered; next grant with both valid goes to requester 0.
REQ-033 ANCHO=4, req0 op=4 a=4'b1100 b=4'b1010 -> res_data=4'b0111.
